// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial bit-pattern detector.
// Holds a runtime-loadable PAT_LEN-bit pattern and compares it against a
// qualified serial stream. Overlapping or non-overlapping match modes are
// selected by OVERLAP. Each match produces a registered single-cycle pulse on out.
// The optional saturating match counter is built only when the macro
// SEQ_DET_COUNT_EN is defined. Otherwise match_count is tied to 0 and cnt_clr is ignored.
module seq_detector_param #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] RESET_PAT = PAT_LEN'(4'b1011),
    parameter bit                 OVERLAP   = 1'b1,
    parameter int                 CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 in_valid,
    input  logic [PAT_LEN-1:0]   pattern,
    input  logic                 pat_load,
    input  logic                 cnt_clr,
    output logic                 out,
    output logic                 armed,
    output logic [CNT_WIDTH-1:0] match_count
);

    // The fill counter only ever needs to reach PAT_LEN-1.
    localparam int               FW       = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_LEN - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [PAT_LEN-1:0]   pat_q, pat_d;
    logic [PAT_LEN-1:0]   hist_q, hist_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic                 out_q, out_d;
    logic                 armed_q, armed_d;
    logic                 match_now;
    logic [FW-1:0]        fill_inc;

    // The oldest history bit is shifted out before it is ever compared.
    logic                 unused_hist_msb;
    assign unused_hist_msb = hist_q[PAT_LEN-1];

    assign fill_inc = fill_q + 1'b1;

    // A load cycle ignores in/in_valid, so it can never complete a match.
    assign match_now = !pat_load && in_valid && (state_q == S_ARMED) &&
                       ({hist_q[PAT_LEN-2:0], in} == pat_q);

    // Next-state logic: pattern load, history shift, fill tracking, match handling.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (pat_load) begin
            pat_d   = pattern;
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_FILL;
        end else if (in_valid) begin
            hist_d = {hist_q[PAT_LEN-2:0], in};
            if (match_now && !OVERLAP) begin
                // Discard history so the next match needs PAT_LEN fresh bits.
                fill_d  = '0;
                state_d = S_FILL;
            end else if (state_q == S_FILL) begin
                fill_d = fill_inc;
                if (fill_inc == FILL_MAX) begin
                    state_d = S_ARMED;
                end
            end
        end
        out_d   = match_now;
        armed_d = (state_d == S_ARMED);
    end

    // State, pattern, history and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            pat_q   <= RESET_PAT;
            hist_q  <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            out_q   <= out_d;
            armed_q <= armed_d;
        end
    end

    assign out   = out_q;
    assign armed = armed_q;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Saturating match counter; a clear wins over a simultaneous match.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match_now && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule
